// File: rtl/regbank_access_seq_pkg.sv
// Shared types and constants for the register-bank access sequencer.
// Used by regbank_instr_decode and regbank_access_seq (REGBANK_R0_ZERO_EN aware).
package regbank_access_seq_pkg;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 3;
  localparam int OPW_DEF = 4;

  // Instruction layout: [15:12] opcode, [11:9] dst, [8:6] src1, [5:3] src2, [2:0] unused
  localparam int OP_LSB   = 12;
  localparam int DST_LSB  = 9;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_LSB = 3;

  localparam logic [OPW_DEF-1:0] OP_NOP = 4'b0000;
  localparam logic [OPW_DEF-1:0] OP_CMP = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT_RES,
    S_WB
  } state_t;

endpackage

// File: rtl/regbank_instr_decode.sv
// Combinational instruction field split plus NOP / write-back flags.
// With REGBANK_R0_ZERO_EN defined, a destination of register 0 never needs write-back.
module regbank_instr_decode
  import regbank_access_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic [DW-1:0]  i_instr,
  output logic [OPW-1:0] o_op,
  output logic [AW-1:0]  o_dst,
  output logic [AW-1:0]  o_src1,
  output logic [AW-1:0]  o_src2,
  output logic           o_is_nop,
  output logic           o_needs_wb
);

  logic w_unused_bits;

  assign o_op   = i_instr[OP_LSB +: OPW];
  assign o_dst  = i_instr[DST_LSB +: AW];
  assign o_src1 = i_instr[SRC1_LSB +: AW];
  assign o_src2 = i_instr[SRC2_LSB +: AW];

  assign o_is_nop = (o_op == OP_NOP);

`ifdef REGBANK_R0_ZERO_EN
  assign o_needs_wb = (o_op != OP_CMP) && (o_dst != '0);
`else
  assign o_needs_wb = (o_op != OP_CMP);
`endif

  assign w_unused_bits = ^i_instr[SRC2_LSB-1:0];

endmodule

// File: rtl/regbank_access_seq.sv
// Register-bank access sequencer: one instruction in flight, bank read -> ALU -> bank write.
// Optional REGBANK_R0_ZERO_EN: register 0 reads as zero and is never written.
module regbank_access_seq
  import regbank_access_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [DW-1:0]  instr,
  output logic [AW-1:0]  rpa1,
  output logic [AW-1:0]  rpa2,
  output logic           rd1,
  output logic           rd2,
  input  logic [DW-1:0]  p1,
  input  logic [DW-1:0]  p2,
  output logic [AW-1:0]  wpa,
  output logic           wr,
  output logic [DW-1:0]  Din,
  output logic           alu_valid,
  input  logic           alu_ready,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic           res_valid,
  input  logic [DW-1:0]  res_data,
  output logic           done,
  output state_t         o_dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both
  // high; the valid side holds its payload stable until that edge.

  logic [OPW-1:0] w_op;
  logic [AW-1:0]  w_dst, w_src1, w_src2;
  logic           w_is_nop, w_needs_wb;
  logic           w_rd1_en, w_rd2_en;

  state_t         r_state;
  logic           r_instr_ready;
  logic [AW-1:0]  r_rpa1, r_rpa2, r_wpa;
  logic           r_rd1, r_rd2, r_wr, r_done, r_alu_valid;
  logic [DW-1:0]  r_din, r_alu_a, r_alu_b;
  logic [OPW-1:0] r_alu_op, r_op;
  logic [AW-1:0]  r_dst;
  logic           r_needs_wb;

  regbank_instr_decode #(.DW(DW), .AW(AW), .OPW(OPW)) u_decode (
    .i_instr    (instr),
    .o_op       (w_op),
    .o_dst      (w_dst),
    .o_src1     (w_src1),
    .o_src2     (w_src2),
    .o_is_nop   (w_is_nop),
    .o_needs_wb (w_needs_wb)
  );

`ifdef REGBANK_R0_ZERO_EN
  assign w_rd1_en = (w_src1 != '0);
  assign w_rd2_en = (w_src2 != '0);
`else
  assign w_rd1_en = 1'b1;
  assign w_rd2_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_instr_ready <= 1'b1;
      r_rpa1        <= '0;
      r_rpa2        <= '0;
      r_wpa         <= '0;
      r_rd1         <= 1'b0;
      r_rd2         <= 1'b0;
      r_wr          <= 1'b0;
      r_done        <= 1'b0;
      r_alu_valid   <= 1'b0;
      r_din         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_op          <= '0;
      r_dst         <= '0;
      r_needs_wb    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op       <= w_op;
            r_dst      <= w_dst;
            r_needs_wb <= w_needs_wb;
            if (w_is_nop) begin
              r_done <= 1'b1;
            end else begin
              r_state       <= S_READ;
              r_instr_ready <= 1'b0;
              r_rd1         <= w_rd1_en;
              r_rd2         <= w_rd2_en;
              r_rpa1        <= w_src1;
              r_rpa2        <= w_src2;
            end
          end
        end
        S_READ: begin
          // A port left disabled (register 0 as zero) supplies a zero operand
          r_alu_a     <= r_rd1 ? p1 : '0;
          r_alu_b     <= r_rd2 ? p2 : '0;
          r_rd1       <= 1'b0;
          r_rd2       <= 1'b0;
          r_alu_op    <= r_op;
          r_alu_valid <= 1'b1;
          r_state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (alu_ready) begin
            r_alu_valid <= 1'b0;
            if (res_valid) begin
              r_din   <= res_data;
              r_wpa   <= r_dst;
              r_wr    <= r_needs_wb;
              r_done  <= 1'b1;
              r_state <= S_WB;
            end else begin
              r_state <= S_WAIT_RES;
            end
          end
        end
        S_WAIT_RES: begin
          if (res_valid) begin
            r_din   <= res_data;
            r_wpa   <= r_dst;
            r_wr    <= r_needs_wb;
            r_done  <= 1'b1;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_state       <= S_IDLE;
          r_instr_ready <= 1'b1;
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign rpa1        = r_rpa1;
  assign rpa2        = r_rpa2;
  assign rd1         = r_rd1;
  assign rd2         = r_rd2;
  assign wpa         = r_wpa;
  assign wr          = r_wr;
  assign Din         = r_din;
  assign alu_valid   = r_alu_valid;
  assign alu_op      = r_alu_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regbank_access_seq.sv
// Self-checking bench for regbank_access_seq: vector table, reset corner cases, random run.
// Expectations adapt to REGBANK_R0_ZERO_EN when it is defined.
module tb_regbank_access_seq;
  import regbank_access_seq_pkg::*;

`ifdef REGBANK_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rpa1, rpa2, wpa;
  logic        rd1, rd2, wr;
  logic [15:0] Din;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        res_valid;
  logic [15:0] res_data;
  logic        done;
  state_t      dbg_state;

  logic [15:0] tb_bank [8];
  logic [15:0] ref_mem [8];
  logic [18:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  wire [15:0] p1 = rd1 ? tb_bank[rpa1] : 16'hzzzz;
  wire [15:0] p2 = rd2 ? tb_bank[rpa2] : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  regbank_access_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rpa1        (rpa1),
    .rpa2        (rpa2),
    .rd1         (rd1),
    .rd2         (rd2),
    .p1          (p1),
    .p2          (p2),
    .wpa         (wpa),
    .wr          (wr),
    .Din         (Din),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rules: NOP and CMP never write; with r0-as-zero, dst 0 is not written.
  function automatic logic model_wr(input logic [15:0] ins);
    logic [3:0] op;
    op = ins[15:12];
    return (op != 4'h0) && (op != 4'hE) && !(R0Z && ins[11:9] == 3'd0);
  endfunction

  // NOP: done one cycle after accept; otherwise READ + ISSUE(1+k) + result wait r + WB.
  function automatic int model_lat(input logic [15:0] ins, input int k, input int r);
    return (ins[15:12] == 4'h0) ? 1 : 3 + k + r;
  endfunction

  // ---------------- driver: one instruction, ALU responder, monitor ----------------
  task automatic run_instr(input logic [15:0] ins, input int rdy_wait, input int res_wait,
                           input logic [15:0] result, input logic exp_wr, input int exp_lat);
    logic [3:0]  op, cap_op;
    logic [2:0]  dst, s1, s2, seen_rpa1, seen_rpa2;
    logic        is_nop, exp_rd1, exp_rd2, hs_pend, res_given;
    logic [15:0] exp_a, exp_b, cap_a, cap_b;
    logic [18:0] exp_w;
    int cyc, post, n_rd1, n_rd2, n_wr, n_done, done_cyc, vcnt, rcnt, hs_n;
    int hold_bad, rdy_bad, bm;
    op = ins[15:12]; dst = ins[11:9]; s1 = ins[8:6]; s2 = ins[5:3];
    is_nop  = (op == 4'h0);
    exp_rd1 = !is_nop && !(R0Z && s1 == 3'd0);
    exp_rd2 = !is_nop && !(R0Z && s2 == 3'd0);
    exp_a   = (R0Z && s1 == 3'd0) ? 16'h0 : ref_mem[s1];
    exp_b   = (R0Z && s2 == 3'd0) ? 16'h0 : ref_mem[s2];
    if (exp_wr) exp_q.push_back({dst, result});
    cyc = 0; post = 0; n_rd1 = 0; n_rd2 = 0; n_wr = 0; n_done = 0; done_cyc = 0;
    vcnt = 0; rcnt = 0; hs_n = 0; hold_bad = 0; rdy_bad = 0;
    hs_pend = 1'b0; res_given = 1'b0; seen_rpa1 = '0; seen_rpa2 = '0;
    cap_a = '0; cap_b = '0; cap_op = '0;

    @(negedge clk);
    check("pre_ready", instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    while (cyc < 100 && post < 2) begin
      @(negedge clk);
      cyc++;
      instr_valid = 1'b0;
      if (hs_pend) begin hs_pend = 1'b0; hs_n++; alu_ready = 1'b0; end
      res_valid = 1'b0;
      // monitor
      if (rd1) begin n_rd1++; seen_rpa1 = rpa1; end
      if (rd2) begin n_rd2++; seen_rpa2 = rpa2; end
      if (wr) begin
        n_wr++;
        tb_bank[wpa] = Din;
        if (exp_q.size() == 0) check("wr_unexpected", wr, 0);
        else begin
          exp_w = exp_q.pop_front();
          check("wr_addr_data", {wpa, Din}, exp_w);
        end
      end
      if (done) begin n_done++; if (n_done == 1) done_cyc = cyc; end
      if (!is_nop && (n_done == 0 || cyc == done_cyc) && instr_ready) rdy_bad++;
      // ALU responder
      if (alu_valid && !hs_pend) begin
        if (vcnt == 0) begin cap_a = alu_a; cap_b = alu_b; cap_op = alu_op; end
        else if (alu_a !== cap_a || alu_b !== cap_b || alu_op !== cap_op) hold_bad++;
        if (vcnt >= rdy_wait) begin
          alu_ready = 1'b1;
          hs_pend = 1'b1;
          if (res_wait == 0) begin res_valid = 1'b1; res_data = result; res_given = 1'b1; end
        end
        vcnt++;
      end else if (hs_n > 0 && !res_given) begin
        rcnt++;
        if (rcnt >= res_wait) begin res_valid = 1'b1; res_data = result; res_given = 1'b1; end
      end
      if (done_cyc != 0 && cyc > done_cyc) post++;
    end
    alu_ready = 1'b0;
    res_valid = 1'b0;

    check("done_count", n_done, 1);
    check("latency", done_cyc, exp_lat);
    check("rd1_cycles", n_rd1, exp_rd1);
    check("rd2_cycles", n_rd2, exp_rd2);
    check("wr_count", n_wr, exp_wr);
    check("alu_handshakes", hs_n, !is_nop);
    check("busy_not_ready", rdy_bad, 0);
    check("alu_hold", hold_bad, 0);
    check("ready_after", instr_ready, 1);
    if (exp_rd1) check("rpa1", seen_rpa1, s1);
    if (exp_rd2) check("rpa2", seen_rpa2, s2);
    if (!is_nop) begin
      check("alu_a", cap_a, exp_a);
      check("alu_b", cap_b, exp_b);
      check("alu_op", cap_op, op);
    end
    if (exp_wr) ref_mem[dst] = result;
    bm = 0;
    for (int i = 0; i < 8; i++) if (tb_bank[i] !== ref_mem[i]) bm++;
    check("bank_state", bm, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] ins;
    int          rdy_wait;
    int          res_wait;
    logic [15:0] result;
    logic        exp_wr;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [15:0] ins, res;
    int k, r, cnt;
    logic seen;

    vecs[0] = '{16'h0000, 0, 0, 16'h0000, 1'b0, 1};   // NOP
    vecs[1] = '{16'h1298, 0, 0, 16'h000C, 1'b1, 3};   // ADD r1 = r2, r3, same-cycle result
    vecs[2] = '{16'hE298, 1, 1, 16'hFFFF, 1'b0, 5};   // CMP: full sequence, no write
    vecs[3] = '{16'h2A50, 5, 3, 16'hBEEF, 1'b1, 11};  // ALU backpressure + late result
    vecs[4] = '{16'h3928, 0, 1, 16'h1234, 1'b1, 4};   // dst == src1
    vecs[5] = '{16'h0FFF, 0, 0, 16'h0000, 1'b0, 1};   // NOP with non-zero fields
    vecs[6] = '{16'hFFF0, 2, 0, 16'hA5A5, 1'b1, 5};   // top opcode / registers

    for (int i = 0; i < 8; i++) tb_bank[i] = 16'h1111 * i[15:0];
    tb_bank[0] = 16'h00AA;
    tb_bank[2] = 16'h0005;
    tb_bank[3] = 16'h0007;
    for (int i = 0; i < 8; i++) ref_mem[i] = tb_bank[i];

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    alu_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_strobes", {rd1, rd2, wr, alu_valid, done}, 5'b0);
    check("rst_addr", {rpa1, rpa2, wpa}, 9'b0);
    check("rst_din", Din, 16'h0);
    check("rst_operands", {alu_a, alu_b}, 32'h0);
    check("rst_alu_op", alu_op, 4'h0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_instr(vecs[i].ins, vecs[i].rdy_wait, vecs[i].res_wait,
                vecs[i].result, vecs[i].exp_wr, vecs[i].exp_lat);

    // Reset while waiting for the result: instruction aborts, late result ignored.
    @(negedge clk);
    instr = 16'h4250; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    cnt = 0;
    while (!alu_valid && cnt < 10) begin @(negedge clk); cnt++; end
    check("rstw_issue", alu_valid, 1);
    alu_ready = 1'b1;
    @(negedge clk);
    alu_ready = 1'b0;
    check("rstw_busy", instr_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    res_valid = 1'b1; res_data = 16'hDEAD;
    check("rstw_idle_ready", instr_ready, 1);
    check("rstw_quiet", {alu_valid, wr, done}, 3'b0);
    check("rstw_din", Din, 16'h0);
    cnt = 0;
    repeat (3) begin @(negedge clk); if (wr || done) cnt++; end
    res_valid = 1'b0;
    check("rstw_no_wr", cnt, 0);

    // Reset during write-back: wr high in the reset cycle is low after the edge.
    @(negedge clk);
    instr = 16'h6A98; instr_valid = 1'b1;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 12) begin
      @(negedge clk);
      cnt++;
      instr_valid = 1'b0; alu_ready = 1'b0; res_valid = 1'b0;
      if (wr) seen = 1'b1;
      else if (alu_valid) begin alu_ready = 1'b1; res_valid = 1'b1; res_data = 16'h4321; end
    end
    check("wbrst_wr_seen", seen, 1);
    check("wbrst_wr", {wpa, Din}, {3'd5, 16'h4321});
    if (seen) tb_bank[wpa] = Din;
    ref_mem[5] = 16'h4321;
    rst_n = 1'b0;
    @(negedge clk);
    check("wbrst_wr_low", {wr, done}, 2'b0);
    rst_n = 1'b1;

    // Register 0 as source and destination (behaviour depends on REGBANK_R0_ZERO_EN).
    run_instr(16'h5018, 0, 0, 16'h7777, model_wr(16'h5018), model_lat(16'h5018, 0, 0));

    // Random instructions against the reference model.
    for (int n = 0; n < 30; n++) begin
      ins = 16'($urandom_range(0, 65535));
      if (n % 7 == 3) ins[15:12] = 4'h0;
      if (n % 7 == 5) ins[15:12] = 4'hE;
      k   = $urandom_range(0, 3);
      r   = $urandom_range(0, 3);
      res = 16'($urandom);
      run_instr(ins, k, r, res, model_wr(ins), model_lat(ins, k, r));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
